// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_pkg
//  Description : Shared types and constants for the SPI round-robin arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    // Width of one SPI transfer unit
    localparam int BYTE_W = 8;

    // Arbiter sequencing states
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GRANT   = 3'd1,
        FETCH   = 3'd2,
        KICK    = 3'd3,
        WAIT_HI = 3'd4,
        WAIT_LO = 3'd5,
        GAP     = 3'd6,
        FINISH  = 3'd7
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin selector. Returns the first set
//                request bit at or after ptr, wrapping modulo N.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    localparam logic [N-1:0] ONE = N'(1);

    int               pos;
    logic [IDX_W-1:0] cand;

    // Scan from the farthest candidate down to ptr so the nearest set bit wins
    always_comb begin
        pos  = 0;
        cand = '0;
        idx  = '0;
        any  = |req;
        for (int k = N - 1; k >= 0; k--) begin
            pos = int'(ptr) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            cand = pos[IDX_W-1:0];
            if (req[cand]) begin
                idx = cand;
            end
        end
        onehot = any ? (ONE << idx) : '0;
    end

endmodule
`default_nettype wire

// File: rtl/spi_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : spi_rr_arbiter
//  Description : Shares one SPI byte engine between NUM_REQ requesters with
//                round-robin arbitration. Each grant is a multi-byte burst
//                with the requester's chip select held low throughout.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_rr_arbiter
    import spi_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int LEN_W   = 4,
    parameter int GAP_CYC = 2,
    parameter int BUSY_TO = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*LEN_W-1:0]  req_len,
    input  logic [NUM_REQ*BYTE_W-1:0] tx_data,
    input  logic [NUM_REQ-1:0]        tx_valid,
    output logic [NUM_REQ-1:0]        tx_ready,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        cs_n,
    output logic [NUM_REQ-1:0]        done,
    output logic                      err,
    output logic                      m_start,
    output logic [BYTE_W-1:0]         m_data,
    input  logic                      m_busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int TMO_W = $clog2(BUSY_TO + 1);
    localparam int GAP_W = $clog2(GAP_CYC + 1);
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    arb_state_t       state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] idx;
    logic [LEN_W-1:0] len_lat;
    logic [LEN_W-1:0] byte_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic [GAP_W-1:0] gap_cnt;

    logic [NUM_REQ-1:0] pick_onehot;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic [NUM_REQ-1:0] idx_onehot;

    assign idx_onehot = ONE << idx;

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req    (req),
        .ptr    (ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // Burst sequencer; every output is a register updated here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            idx      <= '0;
            len_lat  <= '0;
            byte_cnt <= '0;
            tmo_cnt  <= '0;
            gap_cnt  <= '0;
            gnt      <= '0;
            cs_n     <= '1;
            tx_ready <= '0;
            done     <= '0;
            err      <= 1'b0;
            m_start  <= 1'b0;
            m_data   <= '0;
        end else begin
            // Pulse outputs default low every cycle
            tx_ready <= '0;
            done     <= '0;
            err      <= 1'b0;
            m_start  <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        idx     <= pick_idx;
                        len_lat <= req_len[pick_idx*LEN_W +: LEN_W];
                        gnt     <= pick_onehot;
                        cs_n    <= ~pick_onehot;
                        state   <= GRANT;
                    end
                end
                GRANT: begin
                    byte_cnt <= len_lat;
                    // A zero-length burst still consumes the turn
                    state    <= (len_lat == '0) ? FINISH : FETCH;
                end
                FETCH: begin
                    if (tx_valid[idx]) begin
                        tx_ready <= idx_onehot;
                        m_data   <= tx_data[idx*BYTE_W +: BYTE_W];
                        m_start  <= 1'b1;
                        state    <= KICK;
                    end
                end
                KICK: begin
                    // The m_start cycle counts as the first timeout cycle
                    tmo_cnt <= TMO_W'(1);
                    state   <= WAIT_HI;
                end
                WAIT_HI: begin
                    if (m_busy) begin
                        state <= WAIT_LO;
                    end else if (tmo_cnt >= TMO_W'(BUSY_TO - 1)) begin
                        err   <= 1'b1;
                        state <= FINISH;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                WAIT_LO: begin
                    if (!m_busy) begin
                        if (byte_cnt != '0) begin
                            byte_cnt <= byte_cnt - LEN_W'(1);
                        end
                        gap_cnt <= '0;
                        state   <= GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_W'(GAP_CYC - 1)) begin
                        state <= (byte_cnt != '0) ? FETCH : FINISH;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                FINISH: begin
                    gnt   <= '0;
                    cs_n  <= '1;
                    done  <= idx_onehot;
                    ptr   <= (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + IDX_W'(1);
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
